// File: rtl/vdot_pkg.sv
// Shared types and default sizes for the VDOT sequencer.
//   state_e : sequencer state encoding (IDLE / MUL / DONE)
//   *_DEF   : default lane count and element width (LANES*ELEM_W == DATA_W)
package vdot_pkg;

    localparam int unsigned LANES_DEF  = 4;
    localparam int unsigned ELEM_W_DEF = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned PERF_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vdot_mul8.sv
// Combinational element multiplier shared across all lanes.
//   a_i, b_i  : one element from each operand
//   signed_i  : 1 = two's complement elements, 0 = unsigned
//   prod_o    : signed product of the (ELEM_W+1)-bit extended elements
module vdot_mul8 #(
    parameter int unsigned ELEM_W = 8
) (
    input  logic [ELEM_W-1:0]          a_i,
    input  logic [ELEM_W-1:0]          b_i,
    input  logic                       signed_i,
    output logic signed [2*ELEM_W+1:0] prod_o
);

    localparam int unsigned PROD_W = 2 * (ELEM_W + 1);

    logic signed [ELEM_W:0] a_x;
    logic signed [ELEM_W:0] b_x;

    // One extra bit lets a single signed multiplier cover both modes.
    always_comb begin
        a_x    = $signed({signed_i & a_i[ELEM_W-1], a_i});
        b_x    = $signed({signed_i & b_i[ELEM_W-1], b_i});
        prod_o = PROD_W'(a_x) * PROD_W'(b_x);
    end

endmodule

// File: rtl/vdot_seq.sv
// Multi-cycle packed dot-product sequencer: one lane product per cycle.
//   clk, rst (async, active-low)
//   start_valid/start_ready, rs1Data, rs2Data, rdAddr, signed_mode : op issue
//   flush        : synchronous kill of the in-flight or held op
//   res_valid/res_ready, VDOTOut, res_rdAddr : result to writeback
//   busy         : state is not IDLE
//   cnt_clr, busy_cycles : saturating count of non-IDLE cycles
module vdot_seq
    import vdot_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned ELEM_W = ELEM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] rs1Data,
    input  logic [DATA_W-1:0] rs2Data,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              signed_mode,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] VDOTOut,
    output logic [ADDR_W-1:0] res_rdAddr,
    output logic              busy,
    input  logic              cnt_clr,
    output logic [PERF_W-1:0] busy_cycles
);

    localparam int unsigned CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PROD_W = 2 * (ELEM_W + 1);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [PERF_W-1:0] BC_MAX    = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] vdot_q, vdot_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] res_rd_q, res_rd_d;
    logic              sm_q, sm_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  lane_q, lane_d;
    logic [PERF_W-1:0] bc_q, bc_d;

    logic              accept;
    logic              handshake;
    logic              last_lane;
    logic [ELEM_W-1:0] a_lane;
    logic [ELEM_W-1:0] b_lane;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0] prod_ext;

    // Handshake decode; start_ready is combinational so a held result can
    // be retired and the next op accepted on the same edge.
    assign start_ready = !flush && ((state_q == IDLE) ||
                                    ((state_q == DONE) && res_ready));
    assign accept      = start_valid && start_ready;
    assign handshake   = res_valid_q && res_ready;
    assign last_lane   = (lane_q == LAST_LANE);

    // Lane select feeding the single shared multiplier.
    assign a_lane   = op_a_q[lane_q*ELEM_W +: ELEM_W];
    assign b_lane   = op_b_q[lane_q*ELEM_W +: ELEM_W];
    assign prod_ext = DATA_W'(prod);

    vdot_mul8 #(
        .ELEM_W (ELEM_W)
    ) u_mul (
        .a_i      (a_lane),
        .b_i      (b_lane),
        .signed_i (sm_q),
        .prod_o   (prod)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = MUL;
            MUL:  if (last_lane) state_d = DONE;
            DONE: begin
                if (accept)         state_d = MUL;
                else if (handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath and registered-output next values.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        sm_d        = sm_q;
        acc_d       = acc_q;
        lane_d      = lane_q;
        vdot_d      = vdot_q;
        res_rd_d    = res_rd_q;
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);

        if (accept) begin
            op_a_d = rs1Data;
            op_b_d = rs2Data;
            rd_d   = rdAddr;
            sm_d   = signed_mode;
            acc_d  = '0;
            lane_d = '0;
        end else if ((state_q == MUL) && !flush) begin
            acc_d  = acc_q + prod_ext;
            lane_d = lane_q + CNT_W'(1);
            // Result registers only move when a new result is published.
            if (last_lane) begin
                vdot_d   = acc_q + prod_ext;
                res_rd_d = rd_q;
            end
        end

        if (cnt_clr) begin
            bc_d = '0;
        end else if (busy_q && (bc_q != BC_MAX)) begin
            bc_d = bc_q + PERF_W'(1);
        end else begin
            bc_d = bc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            sm_q        <= 1'b0;
            acc_q       <= '0;
            lane_q      <= '0;
            vdot_q      <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bc_q        <= '0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
            sm_q        <= sm_d;
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            vdot_q      <= vdot_d;
            res_rd_q    <= res_rd_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            bc_q        <= bc_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign VDOTOut     = vdot_q;
    assign res_rdAddr  = res_rd_q;
    assign busy        = busy_q;
    assign busy_cycles = bc_q;

endmodule

// File: tb/tb_vdot_seq.sv
// Directed self-checking bench for vdot_seq.
module tb_vdot_seq;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rdAddr;
    logic        signed_mode;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] VDOTOut;
    logic [4:0]  res_rdAddr;
    logic        busy;
    logic        cnt_clr;
    logic [15:0] busy_cycles;

    int errors = 0;
    int checks = 0;

    vdot_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .rs1Data     (rs1Data),
        .rs2Data     (rs2Data),
        .rdAddr      (rdAddr),
        .signed_mode (signed_mode),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .VDOTOut     (VDOTOut),
        .res_rdAddr  (res_rdAddr),
        .busy        (busy),
        .cnt_clr     (cnt_clr),
        .busy_cycles (busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until res_valid; 0 means it never arrived within budget.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (res_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic [4:0] rd);
        rs1Data     = a;
        rs2Data     = b;
        signed_mode = sm;
        rdAddr      = rd;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        rs1Data     = 32'h0;
        rs2Data     = 32'h0;
        rdAddr      = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_valid = 1'b0; rs1Data = '0; rs2Data = '0; rdAddr = '0;
        signed_mode = 1'b0; flush = 1'b0; res_ready = 1'b1; cnt_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({res_valid, busy, VDOTOut, res_rdAddr, busy_cycles} !== 55'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b out=%h rd=%0d bc=%h exp all zero",
                     res_valid, busy, VDOTOut, res_rdAddr, busy_cycles);
        end
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_ready: got %b exp 1", start_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    // Single op with res_ready high: latency, value, rdAddr and return to IDLE.
    task automatic test_dot(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic sm,
                            input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        res_ready = 1'b1;
        issue(a, b, sm, rd);
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_accept: got busy=%b valid=%b exp busy=1 valid=0",
                     name, busy, res_valid);
        end
        wait_result(lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d exp 4", name, lat);
        end
        checks++;
        if (VDOTOut !== exp || res_rdAddr !== rd) begin
            errors++;
            $display("FAIL %s_value: got %h rd=%0d exp %h rd=%0d",
                     name, VDOTOut, res_rdAddr, exp, rd);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || VDOTOut !== exp) begin
            errors++;
            $display("FAIL %s_retire: got valid=%b busy=%b out=%h exp valid=0 busy=0 out=%h",
                     name, res_valid, busy, VDOTOut, exp);
        end
    endtask

    task automatic test_busy_count();
        // First op after reset: 4 MUL cycles + 1 DONE cycle.
        checks++;
        if (busy_cycles !== 16'd5) begin
            errors++;
            $display("FAIL busy_count_first_op: got %0d exp 5", busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        res_ready = 1'b0;
        issue(32'h04030201, 32'h01010101, 1'b0, 5'd5);
        wait_result(lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d exp 4", lat);
        end
        // Pending second op while the result is held.
        rs1Data = 32'hFFFFFFFF; rs2Data = 32'hFFFFFFFF;
        signed_mode = 1'b1; rdAddr = 5'd9; start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || VDOTOut !== 32'h0000000A ||
                res_rdAddr !== 5'd5 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b out=%h rd=%0d ready=%b exp 1 0000000a 5 0",
                         i, res_valid, VDOTOut, res_rdAddr, start_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got ready=%b valid=%b exp 1 1",
                     start_ready, res_valid);
        end
        tick();
        start_valid = 1'b0; rs1Data = '0; rs2Data = '0; rdAddr = '0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || VDOTOut !== 32'h0000000A) begin
            errors++;
            $display("FAIL b2b_accept: got valid=%b busy=%b out=%h exp 0 1 0000000a",
                     res_valid, busy, VDOTOut);
        end
        wait_result(lat);
        checks++;
        if (lat != 4 || VDOTOut !== 32'h00000004 || res_rdAddr !== 5'd9) begin
            errors++;
            $display("FAIL b2b_result: got lat=%0d out=%h rd=%0d exp 4 00000004 9",
                     lat, VDOTOut, res_rdAddr);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] bc;
        res_ready = 1'b1;
        issue(32'h04030201, 32'h01010101, 1'b0, 5'd3);
        tick(); tick();
        flush = 1'b1;
        start_valid = 1'b1; rs1Data = 32'h01010101; rs2Data = 32'h01010101;
        #1;
        checks++;
        if (start_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_ready: got %b exp 0", start_ready);
        end
        bc = busy_cycles;
        tick();
        flush = 1'b0; start_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || busy_cycles !== bc + 16'd1) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b valid=%b bc=%0d exp 0 0 %0d",
                     busy, res_valid, busy_cycles, bc + 16'd1);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || busy_cycles !== bc + 16'd1) begin
                errors++;
                $display("FAIL flush_quiet%0d: got valid=%b busy=%b bc=%0d exp 0 0 %0d",
                         i, res_valid, busy, busy_cycles, bc + 16'd1);
            end
        end
    endtask

    task automatic test_saturate();
        res_ready = 1'b0;
        issue(32'h00000001, 32'h00000001, 1'b0, 5'd1);
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if (busy_cycles !== 16'hFFFF || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_value: got bc=%h valid=%b exp ffff 1", busy_cycles, res_valid);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (busy_cycles !== 16'h0000) begin
            errors++;
            $display("FAIL sat_clear: got %h exp 0000", busy_cycles);
        end
        tick();
        checks++;
        if (busy_cycles !== 16'h0001) begin
            errors++;
            $display("FAIL sat_recount: got %h exp 0001", busy_cycles);
        end
        res_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_op();
        res_ready = 1'b1;
        issue(32'h04030201, 32'h01010101, 1'b0, 5'd7);
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({res_valid, busy, VDOTOut, res_rdAddr, busy_cycles} !== 55'h0 ||
            start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op: got valid=%b busy=%b out=%h rd=%0d bc=%h ready=%b exp zeros ready=1",
                     res_valid, busy, VDOTOut, res_rdAddr, busy_cycles, start_ready);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_result%0d: got valid=%b busy=%b exp 0 0",
                         i, res_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dot("unsigned", 32'h04030201, 32'h01010101, 1'b0, 5'd5, 32'h0000000A);
        test_busy_count();
        test_dot("signed", 32'hFFFFFFFF, 32'h02020202, 1'b1, 5'd2, 32'hFFFFFFF8);
        test_dot("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd31, 32'h0003F804);
        test_dot("smax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd30, 32'h00000004);
        test_dot("mixed_s", 32'h80FF7F01, 32'h807F0302, 1'b1, 5'd12, 32'h00004100);
        test_dot("mixed_u", 32'h80FF7F01, 32'h807F0302, 1'b0, 5'd13, 32'h0000C000);
        test_back_to_back();
        test_flush();
        test_saturate();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
